// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared types and constants for truth_table_checker
//
// Contents:
//   state_e    - sweep FSM states
//   vec_count  - number of input vectors for an N-input netlist (2**n_in)
//   TT_0X918A  - default expected truth table

package ttc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic [15:0] TT_0X918A = 16'h918A;

    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/ttc_settle_timer.sv
// rtl/ttc_settle_timer.sv - loadable down-counter with zero flag for the vector hold time
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset
//   load_i      - load load_val_i (has priority over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one; holds at zero
//   zero_o      - counter currently equals zero

module ttc_settle_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive truth-table sweep and checker for an N-input gate netlist
//
// Optional feature macro: TTC_FAIL_MAP_EN (per-vector mismatch bitmap on fail_map;
// when undefined fail_map is constant zero and no map register exists).
//
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   start          - one-cycle sweep request, honoured only in IDLE
//   dut_in         - vector driven into the netlist (0 outside a sweep)
//   dut_out        - netlist output
//   busy           - high from the cycle after an accepted start through DONE
//   done           - one-cycle pulse at end of sweep
//   pass           - last sweep had zero mismatches
//   fail_count     - mismatches in last sweep
//   first_fail_idx - lowest failing vector (valid when fail_count != 0)
//   fail_map       - per-vector mismatch bitmap

module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int unsigned N_IN          = 4,
    parameter              EXPECTED      = TT_0X918A,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [N_IN-1:0]            dut_in,
    input  logic                       dut_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_IN:0]              fail_count,
    output logic [N_IN-1:0]            first_fail_idx,
    output logic [vec_count(N_IN)-1:0] fail_map
);

    localparam int unsigned       V           = vec_count(N_IN);
    localparam int unsigned       FCW         = N_IN + 1;
    localparam int unsigned       CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [V-1:0]      EXP_TT      = V'(EXPECTED);
    localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]   IDX_LAST    = N_IN'(V - 1);

    if ($bits(EXPECTED) != V) begin : g_bad_expected_width
        $error("truth_table_checker: EXPECTED width must equal 2**N_IN");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("truth_table_checker: SETTLE_CYCLES must be >= 1");
    end

    state_e          state_q,      state_d;
    logic [N_IN-1:0] idx_q,        idx_d;
    logic [FCW-1:0]  fail_count_q, fail_count_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            pass_q,       pass_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic start_accept;
    logic mismatch;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign mismatch     = (dut_out != EXP_TT[idx_q]);

    ttc_settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    idx_d        = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    timer_load   = 1'b1;
                end
            end
            ST_APPLY: begin
                // The timer was loaded with SETTLE_CYCLES-1, so reaching zero here
                // means this is the last hold cycle of the vector.
                timer_dec = 1'b1;
                if (timer_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + FCW'(1);
                    if (fail_count_q == '0) begin
                        first_fail_d = idx_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    // Includes this final sample so pass is correct in the DONE cycle.
                    pass_d  = (fail_count_d == '0);
                end else begin
                    state_d    = ST_APPLY;
                    idx_d      = idx_q + N_IN'(1);
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

`ifdef TTC_FAIL_MAP_EN
    logic [V-1:0] fail_map_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_map_q <= '0;
        end else if (start_accept) begin
            fail_map_q <= '0;
        end else if ((state_q == ST_SAMPLE) && mismatch) begin
            fail_map_q[idx_q] <= 1'b1;
        end
    end

    assign fail_map = fail_map_q;
`else
    assign fail_map = '0;
`endif

    assign dut_in         = ((state_q == ST_APPLY) || (state_q == ST_SAMPLE)) ? idx_q : '0;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - self-checking bench for truth_table_checker
`timescale 1ns/1ps

module tb_truth_table_checker;

    localparam logic [15:0] EXP16 = 16'h918A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;
    logic [15:0] fail_map;
    logic [15:0] net_tt;

    assign dut_out = net_tt[dut_in];

    truth_table_checker u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .fail_map       (fail_map)
    );

    logic       start2;
    logic [2:0] dut_in2;
    logic       dut_out2;
    logic       busy2, done2, pass2;
    logic [3:0] fail_count2;
    logic [2:0] first_fail_idx2;
    logic [7:0] fail_map2;
    logic [7:0] net_tt2;

    assign dut_out2 = net_tt2[dut_in2];

    truth_table_checker #(
        .N_IN          (3),
        .EXPECTED      (8'h96),
        .SETTLE_CYCLES (1)
    ) u_small (
        .clk            (clk),
        .rst            (rst),
        .start          (start2),
        .dut_in         (dut_in2),
        .dut_out        (dut_out2),
        .busy           (busy2),
        .done           (done2),
        .pass           (pass2),
        .fail_count     (fail_count2),
        .first_fail_idx (first_fail_idx2),
        .fail_map       (fail_map2)
    );

    int tests = 0;
    int fails = 0;

    // Observations from the most recent sweep of u_dut
    int          done_cnt, done_at, busy_err, seq_err;
    logic        cap_pass;
    logic [4:0]  cap_fc;
    logic [3:0]  cap_ff;
    logic [15:0] cap_map;

    function automatic logic [15:0] map_exp(input logic [15:0] m);
`ifdef TTC_FAIL_MAP_EN
        return m;
`else
        return 16'h0000;
`endif
    endfunction

    // Reference: compare every vector of the netlist table against the expected table.
    task automatic model(input logic [15:0] tt, output int fc, output int ff, output logic [15:0] mp);
        logic [15:0] e;
        e  = EXP16;
        fc = 0;
        ff = 0;
        mp = 16'h0;
        for (int k = 0; k < 16; k++) begin
            if (tt[k] != e[k]) begin
                if (fc == 0) ff = k;
                fc = fc + 1;
                mp[k] = 1'b1;
            end
        end
    endtask

    // Pulse start, then observe 60 cycles; re1/re2 are cycles at which start is re-pulsed.
    task automatic run_sweep(input int re1, input int re2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        done_cnt = 0; done_at = 0; busy_err = 0; seq_err = 0;
        for (int j = 1; j <= 60; j++) begin
            if (j > 1) @(negedge clk);
            if (busy !== (j <= 49)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at  = j;
                cap_pass = pass;
                cap_fc   = fail_count;
                cap_ff   = first_fail_idx;
                cap_map  = fail_map;
            end
            if (j <= 48 && dut_in !== 4'((j - 1) / 3)) seq_err++;
            start = (j == re1) || (j == re2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        net_tt = EXP16; net_tt2 = 8'h96;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %0b want 0", pass); end
        tests++; if (dut_in !== 4'h0) begin fails++; $display("FAIL reset_dut_in got %0h want 0", dut_in); end
        tests++; if (fail_count !== 5'd0) begin fails++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
        tests++; if (first_fail_idx !== 4'd0) begin fails++; $display("FAIL reset_first_fail got %0d want 0", first_fail_idx); end
        tests++; if (fail_map !== 16'h0) begin fails++; $display("FAIL reset_fail_map got %0h want 0", fail_map); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_correct;
        net_tt = EXP16;
        run_sweep(0, 0);
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL correct_done_count got %0d want 1", done_cnt); end
        tests++; if (done_at !== 49) begin fails++; $display("FAIL correct_done_cycle got %0d want 49", done_at); end
        tests++; if (busy_err !== 0) begin fails++; $display("FAIL correct_busy_window got %0d bad cycles want 0", busy_err); end
        tests++; if (seq_err !== 0) begin fails++; $display("FAIL correct_dut_in_seq got %0d bad cycles want 0", seq_err); end
        tests++; if (cap_pass !== 1'b1) begin fails++; $display("FAIL correct_pass got %0b want 1", cap_pass); end
        tests++; if (cap_fc !== 5'd0) begin fails++; $display("FAIL correct_fail_count got %0d want 0", cap_fc); end
        tests++; if (cap_map !== 16'h0) begin fails++; $display("FAIL correct_fail_map got %0h want 0", cap_map); end
    endtask

    task automatic test_stuck0;
        net_tt = 16'h0000;
        run_sweep(0, 0);
        tests++; if (cap_pass !== 1'b0) begin fails++; $display("FAIL stuck0_pass got %0b want 0", cap_pass); end
        tests++; if (cap_fc !== 5'd6) begin fails++; $display("FAIL stuck0_fail_count got %0d want 6", cap_fc); end
        tests++; if (cap_ff !== 4'd1) begin fails++; $display("FAIL stuck0_first_fail got %0d want 1", cap_ff); end
        tests++; if (cap_map !== map_exp(16'h918A)) begin fails++; $display("FAIL stuck0_fail_map got %0h want %0h", cap_map, map_exp(16'h918A)); end
        // Results must still hold well after DONE
        tests++; if (fail_count !== 5'd6) begin fails++; $display("FAIL stuck0_hold_count got %0d want 6", fail_count); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL stuck0_hold_pass got %0b want 0", pass); end
    endtask

    task automatic test_inverted;
        net_tt = ~EXP16;
        run_sweep(0, 0);
        tests++; if (cap_fc !== 5'd16) begin fails++; $display("FAIL inverted_fail_count got %0d want 16", cap_fc); end
        tests++; if (cap_ff !== 4'd0) begin fails++; $display("FAIL inverted_first_fail got %0d want 0", cap_ff); end
        tests++; if (cap_pass !== 1'b0) begin fails++; $display("FAIL inverted_pass got %0b want 0", cap_pass); end
        tests++; if (cap_map !== map_exp(16'hFFFF)) begin fails++; $display("FAIL inverted_fail_map got %0h want %0h", cap_map, map_exp(16'hFFFF)); end
    endtask

    task automatic test_restart_ignored;
        net_tt = EXP16;
        run_sweep(10, 49);
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
        tests++; if (done_at !== 49) begin fails++; $display("FAIL restart_done_cycle got %0d want 49", done_at); end
        tests++; if (seq_err !== 0) begin fails++; $display("FAIL restart_dut_in_seq got %0d bad cycles want 0", seq_err); end
        tests++; if (busy_err !== 0) begin fails++; $display("FAIL restart_busy_window got %0d bad cycles want 0", busy_err); end
    endtask

    task automatic test_reset_mid_sweep;
        int d_cnt, b_cnt;
        net_tt = 16'h0000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        tests++; if (fail_count === 5'd0) begin fails++; $display("FAIL midrst_precount got %0d want nonzero", fail_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %0b want 0", busy); end
        tests++; if (dut_in !== 4'h0) begin fails++; $display("FAIL midrst_dut_in got %0h want 0", dut_in); end
        tests++; if (fail_count !== 5'd0) begin fails++; $display("FAIL midrst_fail_count got %0d want 0", fail_count); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL midrst_pass got %0b want 0", pass); end
        tests++; if (fail_map !== 16'h0) begin fails++; $display("FAIL midrst_fail_map got %0h want 0", fail_map); end
        d_cnt = 0; b_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done === 1'b1) d_cnt++;
            if (busy === 1'b1) b_cnt++;
        end
        tests++; if (d_cnt !== 0) begin fails++; $display("FAIL midrst_no_done got %0d pulses want 0", d_cnt); end
        tests++; if (b_cnt !== 0) begin fails++; $display("FAIL midrst_no_resume got %0d busy cycles want 0", b_cnt); end
        net_tt = EXP16;
        run_sweep(0, 0);
        tests++; if (done_at !== 49) begin fails++; $display("FAIL midrst_resweep_done got %0d want 49", done_at); end
        tests++; if (cap_pass !== 1'b1) begin fails++; $display("FAIL midrst_resweep_pass got %0b want 1", cap_pass); end
    endtask

    task automatic test_random;
        int fc, ff;
        logic [15:0] mp;
        for (int it = 0; it < 5; it++) begin
            net_tt = 16'($urandom);
            model(net_tt, fc, ff, mp);
            run_sweep(0, 0);
            tests++; if (done_at !== 49) begin fails++; $display("FAIL rand_done_cycle got %0d want 49", done_at); end
            tests++; if (cap_fc !== 5'(fc)) begin fails++; $display("FAIL rand_fail_count tt=%0h got %0d want %0d", net_tt, cap_fc, fc); end
            tests++; if (cap_pass !== (fc == 0)) begin fails++; $display("FAIL rand_pass tt=%0h got %0b want %0b", net_tt, cap_pass, fc == 0); end
            if (fc != 0) begin
                tests++; if (cap_ff !== 4'(ff)) begin fails++; $display("FAIL rand_first_fail tt=%0h got %0d want %0d", net_tt, cap_ff, ff); end
            end
            tests++; if (cap_map !== map_exp(mp)) begin fails++; $display("FAIL rand_fail_map tt=%0h got %0h want %0h", net_tt, cap_map, map_exp(mp)); end
        end
    endtask

    task automatic test_small_config;
        int d_at;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            net_tt2 = (pass_no == 0) ? 8'h96 : 8'h00;
            @(negedge clk); start2 = 1'b1;
            @(negedge clk); start2 = 1'b0;
            d_at = 0;
            for (int j = 1; j <= 30; j++) begin
                if (j > 1) @(negedge clk);
                if (done2 === 1'b1 && d_at == 0) d_at = j;
            end
            tests++; if (d_at !== 17) begin fails++; $display("FAIL small_done_cycle got %0d want 17", d_at); end
            if (pass_no == 0) begin
                tests++; if (pass2 !== 1'b1) begin fails++; $display("FAIL small_pass got %0b want 1", pass2); end
                tests++; if (fail_count2 !== 4'd0) begin fails++; $display("FAIL small_fail_count got %0d want 0", fail_count2); end
            end else begin
                tests++; if (pass2 !== 1'b0) begin fails++; $display("FAIL small_stuck_pass got %0b want 0", pass2); end
                tests++; if (fail_count2 !== 4'd4) begin fails++; $display("FAIL small_stuck_count got %0d want 4", fail_count2); end
                tests++; if (first_fail_idx2 !== 3'd1) begin fails++; $display("FAIL small_stuck_first got %0d want 1", first_fail_idx2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck0();
        test_inverted();
        test_restart_ignored();
        test_reset_mid_sweep();
        test_random();
        test_small_config();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
